// File: rtl/demux1to2_buf_pkg.sv
// rtl/demux1to2_buf_pkg.sv - shared widths, depth and port-select type for the buffered 1:2 demux
package demux1to2_buf_pkg;

  localparam int DATA_W    = 16;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 16;

  typedef enum logic {
    PORT2 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

  // Ring-buffer pointer advance; callers cast back to their pointer width.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo2.sv
// rtl/fifo2.sv - one DEPTH-entry output buffer with occupancy; head word shown combinationally
module fifo2
  import demux1to2_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push_en;
  logic             pop_en;

  assign valid   = (occ != '0);
  assign full    = (occ == OCC_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign push_en = push && !full;
  assign pop_en  = pop && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      end
      if (pop_en) begin
        rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_en, pop_en})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux1to2_buf.sv
// rtl/demux1to2_buf.sv - steers each accepted word into one of two buffered output ports and counts them
module demux1to2_buf
  import demux1to2_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             switch,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  port_sel_e sel;
  logic      full1;
  logic      full2;
  logic      accept;
  logic      push1;
  logic      push2;

  assign sel = port_sel_e'(switch);

  // Readiness depends only on registered occupancy, so a full port stays
  // blocked even in a cycle where its consumer pops.
  assign in_ready = (sel == PORT1) ? !full1 : !full2;
  assign accept   = in_valid && in_ready;
  assign push1    = accept && (sel == PORT1);
  assign push2    = accept && (sel == PORT2);

  fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_port1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .valid     (out1_valid),
    .full      (full1),
    .head      (out1_data)
  );

  fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_port2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2),
    .push_data (in_data),
    .pop       (out2_ready),
    .valid     (out2_valid),
    .full      (full2),
    .head      (out2_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (push1) cnt1 <= cnt1 + CNT_W'(1);
      if (push2) cnt2 <= cnt2 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb/tb_demux1to2_buf.sv - directed and random scoreboard bench for demux1to2_buf
module tb_demux1to2_buf;

  localparam int W = 16;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         switch;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;
  logic         out2_valid;
  logic         out2_ready;
  logic [W-1:0] out2_data;
  logic [15:0]  cnt1;
  logic [15:0]  cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  logic [15:0]  m_cnt1;
  logic [15:0]  m_cnt2;

  demux1to2_buf dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .switch     (switch),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port queues of words the buffer should hold.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      q1.delete();
      q2.delete();
      m_cnt1 = '0;
      m_cnt2 = '0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_out2_valid", 32'(out2_valid), 32'd0);
      chk("rst_out1_data", 32'(out1_data), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
    end else begin
      exp_rdy = switch ? (q1.size() < D) : (q2.size() < D);
      chk("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("mon_cnt1", 32'(cnt1), 32'(m_cnt1));
      chk("mon_cnt2", 32'(cnt2), 32'(m_cnt2));
      chk("mon_out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      chk("mon_out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
      if (q1.size() != 0) begin
        chk("mon_out1_data", 32'(out1_data), 32'(q1[0]));
        if (out1_ready) void'(q1.pop_front());
      end
      if (q2.size() != 0) begin
        chk("mon_out2_data", 32'(out2_data), 32'(q2[0]));
        if (out2_ready) void'(q2.pop_front());
      end
      if (in_valid && exp_rdy) begin
        if (switch) begin
          q1.push_back(in_data);
          m_cnt1 = m_cnt1 + 16'd1;
        end else begin
          q2.push_back(in_data);
          m_cnt2 = m_cnt2 + 16'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_data    = '0;
    switch     = 1'b1;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out1_valid", 32'(out1_valid), 32'd0);
    chk("reset_cnt2", 32'(cnt2), 32'd0);
    step();
    rst = 1'b0;

    // Single word to port 1 appears one cycle later.
    switch = 1'b1; in_data = 16'hABCD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("abcd_out1_valid", 32'(out1_valid), 32'd1);
    chk("abcd_out1_data", 32'(out1_data), 32'hABCD);
    chk("abcd_out2_valid", 32'(out2_valid), 32'd0);
    chk("abcd_cnt1", 32'(cnt1), 32'd1);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;

    // Fill port 2, then a third word is refused.
    switch = 1'b0; in_valid = 1'b1; in_data = 16'hBBBB;
    step();
    in_data = 16'hCCCC;
    step();
    in_data = 16'hDDDD;
    #1;
    chk("full_out2_data", 32'(out2_data), 32'hBBBB);
    chk("full_in_ready_sw0", 32'(in_ready), 32'd0);
    switch = 1'b1; in_valid = 1'b0;
    #1;
    chk("full_in_ready_sw1", 32'(in_ready), 32'd1);
    switch = 1'b0; in_valid = 1'b1;
    step();
    chk("dddd_refused_cnt2", 32'(cnt2), 32'd2);
    chk("dddd_refused_head", 32'(out2_data), 32'hBBBB);

    // Full and popping: still not ready.
    out2_ready = 1'b1;
    #1;
    chk("pop_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    step();
    chk("pop_full_out2_data", 32'(out2_data), 32'hCCCC);
    chk("pop_full_in_ready_after", 32'(in_ready), 32'd1);
    step();
    chk("pop_empty_out2_valid", 32'(out2_valid), 32'd0);
    idle();

    // Alternate ports with both consumers ready.
    do_reset();
    out1_ready = 1'b1; out2_ready = 1'b1; in_valid = 1'b1;
    switch = 1'b1; in_data = 16'h1111;
    step();
    chk("alt_out1_1111", 32'(out1_data), 32'h1111);
    switch = 1'b0; in_data = 16'h2222;
    step();
    chk("alt_out2_2222", 32'(out2_data), 32'h2222);
    switch = 1'b1; in_data = 16'h3333;
    step();
    chk("alt_out1_3333", 32'(out1_data), 32'h3333);
    chk("alt_cnt1", 32'(cnt1), 32'd2);
    chk("alt_cnt2", 32'(cnt2), 32'd1);
    idle();
    step();
    step();

    // Asynchronous reset with port 1 holding two words.
    switch = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    step();
    in_data = 16'h6666;
    step();
    idle();
    chk("pre_rst_out1_valid", 32'(out1_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("async_rst_out1_data", 32'(out1_data), 32'd0);
    step();
    rst = 1'b0;
    switch = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA;
    step();
    idle();
    chk("post_rst_out1_data", 32'(out1_data), 32'hAAAA);
    out1_ready = 1'b1;
    step();
    idle();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      in_valid   = $urandom_range(0, 3) != 0;
      switch     = $urandom_range(0, 1) == 1;
      in_data    = W'($urandom);
      out1_ready = $urandom_range(0, 2) != 0;
      out2_ready = $urandom_range(0, 2) != 0;
      step();
    end
    rst = 1'b0;
    idle();

    // Counter wrap on port 1.
    do_reset();
    switch = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = W'(i);
      step();
    end
    idle();
    chk("wrap_cnt1", 32'(cnt1), 32'd0);
    chk("wrap_cnt2", 32'(cnt2), 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
